lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the execute stage and the byte-addressed `data_memory`.
- Accepts one load or store request per transaction through a valid/ready handshake.
- Drives the memory's `mem_read`, `mem_write`, `addr`, `write_data` and `byte_enable` pins.
- Returns sign- or zero-extended load data, or a fault, through a valid/ready response channel.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_load_extend.sv | 21 ++
 rtl/lsu_mem_ctrl.sv | 138 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, fault causes and FSM states for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_e;

  // Access size minus one (0, 1 or 3); funct3[2] only selects signedness.
  function automatic logic [2:0] size_m1(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_m1 = 3'd0;
      2'b01:   size_m1 = 3'd1;
      default: size_m1 = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of raw load data by funct3 width code
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   result = {24'b0, raw[7:0]};
      F3_HU:   result = {16'b0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store initiator: request check, one-cycle memory access, held response
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int MEM_BYTES   = 1024,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_fault,
  output logic [1:0]           rsp_cause,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [31:0]          mem_rdata
);

  lsu_state_e state, next_state;

  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 fault_q;
  logic [1:0]           cause_q;

  logic                 illegal, out_range, misalign;
  logic [1:0]           req_cause;
  logic [ADDR_BITS:0]   end_addr;
  logic [31:0]          ext_data;
  logic                 access;

  // The extra top bit of end_addr catches accesses running past the last byte.
  always_comb begin
    illegal   = req_is_store ? (req_funct3 > F3_W)
                             : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    end_addr  = {1'b0, req_addr[ADDR_BITS-1:0]}
              + {{(ADDR_BITS-2){1'b0}}, size_m1(req_funct3)};
    out_range = end_addr[ADDR_BITS] || (|req_addr[31:ADDR_BITS]);
    misalign  = ALIGN_CHECK &&
                ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
    req_cause = CAUSE_NONE;
    if (illegal)        req_cause = CAUSE_ILLEGAL;
    else if (out_range) req_cause = CAUSE_RANGE;
    else if (misalign)  req_cause = CAUSE_MISALIGN;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (req_valid) next_state = (req_cause == CAUSE_NONE) ? S_ACCESS : S_RESP;
      S_ACCESS: next_state = S_RESP;
      S_RESP:   if (rsp_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          is_store_q <= req_is_store;
          funct3_q   <= req_funct3;
          addr_q     <= req_addr[ADDR_BITS-1:0];
          wdata_q    <= req_wdata;
          rdata_q    <= '0;
          fault_q    <= (req_cause != CAUSE_NONE);
          cause_q    <= req_cause;
        end
        S_ACCESS: rdata_q <= is_store_q ? 32'b0 : ext_data;
        default: ;
      endcase
    end
  end

  lsu_load_extend u_extend (
    .funct3 (funct3_q),
    .raw    (mem_rdata),
    .result (ext_data)
  );

  // Gating with rst_n lets a reset landing in ACCESS cancel the store before the commit edge.
  assign access = (state == S_ACCESS) && rst_n;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    if (access) begin
      mem_addr = addr_q;
      mem_read = !is_store_q;
      if (is_store_q) begin
        mem_write = 1'b1;
        case (funct3_q[1:0])
          2'b00:   begin mem_be = 4'b0001; mem_wdata = {24'b0, wdata_q[7:0]};  end
          2'b01:   begin mem_be = 4'b0011; mem_wdata = {16'b0, wdata_q[15:0]}; end
          default: begin mem_be = 4'b1111; mem_wdata = wdata_q;                end
        endcase
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign rsp_cause = cause_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl against a transaction-level model
module tb_lsu_mem_ctrl;

  localparam int AB = 10;
  localparam int MB = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_is_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_fault;
  logic [1:0]    rsp_cause;
  logic          mem_read, mem_write;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_BITS(AB), .MEM_BYTES(MB), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .rsp_cause(rsp_cause),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Byte-addressed data memory the DUT talks to, and the model's own copy.
  logic [7:0] ram     [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];

  always_comb begin
    mem_rdata = {ram[mem_addr + 10'd3], ram[mem_addr + 10'd2],
                 ram[mem_addr + 10'd1], ram[mem_addr]};
  end

  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) ram[mem_addr + 10'(i)] <= mem_wdata[8*i +: 8];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit            chk_en = 1'b0;
  bit            exp_partial = 1'b0;
  logic          exp_req_ready, exp_rsp_valid, exp_mem_read, exp_mem_write, exp_rsp_fault;
  logic [AB-1:0] exp_mem_addr;
  logic [3:0]    exp_mem_be;
  logic [31:0]   exp_mem_wdata, exp_rsp_rdata;
  logic [1:0]    exp_rsp_cause;

  always @(negedge clk) begin
    if (chk_en) begin
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      check("mem_write", 32'(mem_write), 32'(exp_mem_write));
      if (!exp_partial) begin
        check("req_ready", 32'(req_ready), 32'(exp_req_ready));
        check("mem_read",  32'(mem_read),  32'(exp_mem_read));
        check("mem_addr",  32'(mem_addr),  32'(exp_mem_addr));
        check("mem_be",    32'(mem_be),    32'(exp_mem_be));
        check("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_rsp_valid) begin
        check("rsp_rdata", rsp_rdata, exp_rsp_rdata);
        check("rsp_fault", 32'(rsp_fault), 32'(exp_rsp_fault));
        check("rsp_cause", 32'(rsp_cause), 32'(exp_rsp_cause));
      end
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [1:0] model_cause(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
    if (longint'(a) + sz - 1 >= MB) return 2'b10;
    if (sz > 1 && (a % sz) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    longint v = 0;
    int sz = size_of(f3);
    for (int i = sz - 1; i >= 0; i--) v = v * 256 + ref_mem[a + i];
    if (f3 == 3'd0 && v >= 128)   v = v - 256;
    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    return 32'(v);
  endfunction

  task automatic set_idle_exp();
    exp_partial = 1'b0;
    exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    exp_mem_read = 1'b0; exp_mem_write = 1'b0;
    exp_mem_addr = '0; exp_mem_be = 4'b0; exp_mem_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    req_valid = 1'($urandom_range(0, 1));
    req_is_store = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  // Starts at 1 time unit after a rising edge with the DUT idle.
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int delay,
                     output logic [31:0] r, output logic f, output logic [1:0] c);
    logic [1:0] cause = model_cause(st, f3, a);
    bit ok = (cause == 2'b00);
    int sz = size_of(f3);
    logic [31:0] mask = (sz == 1) ? 32'h000000FF : (sz == 2) ? 32'h0000FFFF : 32'hFFFFFFFF;
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    set_idle_exp();
    step();
    junk();
    exp_req_ready = 1'b0;
    if (ok) begin
      exp_mem_read = !st; exp_mem_write = st; exp_mem_addr = a[AB-1:0];
      exp_mem_be = !st ? 4'b0000 : (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
      exp_mem_wdata = st ? (wd & mask) : 32'b0;
      exp_rsp_rdata = st ? 32'b0 : model_load(f3, a);
      step();
      junk();
      if (st) for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      exp_rsp_rdata = 32'b0;
    end
    exp_mem_read = 1'b0; exp_mem_write = 1'b0; exp_mem_addr = '0;
    exp_mem_be = 4'b0; exp_mem_wdata = '0;
    exp_rsp_valid = 1'b1; exp_rsp_fault = !ok; exp_rsp_cause = cause;
    for (int i = 0; i < delay; i++) begin
      rsp_ready = 1'b0;
      junk();
      step();
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    r = rsp_rdata; f = rsp_fault; c = rsp_cause;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_idle_exp();
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    check({tag, "_rsp_cause"}, 32'(rsp_cause), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r;
  logic        f;
  logic [1:0]  c;

  initial begin
    for (int i = 0; i < MB; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    step(); step();
    set_idle_exp();
    chk_en = 1'b1;
    check_reset_values("reset");
    rst_n = 1'b1;

    txn(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, r, f, c);
    txn(1'b0, 3'b010, 32'h010, 32'h0, 0, r, f, c);
    check("lw_010", r, 32'hDEADBEEF);
    check("lw_010_fault", 32'(f), 32'd0);

    txn(1'b1, 3'b000, 32'h021, 32'h00000080, 0, r, f, c);
    txn(1'b0, 3'b000, 32'h021, 32'h0, 0, r, f, c);
    check("lb_021", r, 32'hFFFFFF80);
    txn(1'b0, 3'b100, 32'h021, 32'h0, 0, r, f, c);
    check("lbu_021", r, 32'h00000080);
    txn(1'b1, 3'b001, 32'h022, 32'h00008001, 0, r, f, c);
    txn(1'b0, 3'b001, 32'h022, 32'h0, 0, r, f, c);
    check("lh_022", r, 32'hFFFF8001);

    txn(1'b0, 3'b010, 32'h3FE, 32'h0, 0, r, f, c);
    check("lw_3fe_cause", 32'(c), 32'd2);
    check("lw_3fe_fault", 32'(f), 32'd1);
    txn(1'b0, 3'b001, 32'h005, 32'h0, 0, r, f, c);
    check("lh_005_cause", 32'(c), 32'd1);
    txn(1'b0, 3'b011, 32'h000, 32'h0, 0, r, f, c);
    check("ld_illegal_cause", 32'(c), 32'd3);
    txn(1'b1, 3'b001, 32'h3FF, 32'hFFFFFFFF, 0, r, f, c);
    check("sh_3ff_cause", 32'(c), 32'd2);
    txn(1'b0, 3'b001, 32'h3FE, 32'h0, 0, r, f, c);
    check("lh_3fe_unchanged", r, 32'h0);

    txn(1'b0, 3'b010, 32'h010, 32'h0, 5, r, f, c);
    check("lw_backpressure", r, 32'hDEADBEEF);

    // Reset lands in the ACCESS cycle of a word store.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h040; req_wdata = 32'h12345678;
    set_idle_exp();
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    exp_partial = 1'b1; exp_mem_write = 1'b0; exp_rsp_valid = 1'b0;
    step();
    set_idle_exp();
    check_reset_values("mid_store_reset");
    rst_n = 1'b1;
    txn(1'b0, 3'b010, 32'h040, 32'h0, 0, r, f, c);
    check("lw_040_after_reset", r, 32'h00000000);

    txn(1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 0, r, f, c);
    txn(1'b0, 3'b010, 32'h100, 32'h0, 0, r, f, c);
    check("b2b_lw_100", r, 32'hCAFEF00D);
    txn(1'b1, 3'b010, 32'h104, 32'h0BADC0DE, 0, r, f, c);
    txn(1'b0, 3'b010, 32'h104, 32'h0, 0, r, f, c);
    check("b2b_lw_104", r, 32'h0BADC0DE);

    for (int n = 0; n < 400; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          pick = $urandom_range(0, 99);
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
        endcase
      end else f3 = 3'($urandom);
      if (pick < 60)      a = $urandom_range(0, 255) & ~32'(size_of(f3) - 1);
      else if (pick < 75) a = $urandom_range(0, 255);
      else if (pick < 90) a = $urandom_range(MB - 8, MB - 1);
      else                a = $urandom;
      txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 3), r, f, c);
    end

    begin
      int nbad = 0;
      for (int i = 0; i < MB; i++) if (ram[i] !== ref_mem[i]) nbad++;
      check("mem_image", 32'(nbad), 32'd0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
